// File: rtl/uart_pkg.sv
// Shared definitions for the UART line path: ASCII control characters,
// line buffer FSM encoding and byte classification helpers.
package uart_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } line_state_e;

    function automatic logic is_terminator(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

    function automatic logic is_edit(input logic [7:0] b);
        return (b == CHAR_BS) || (b == CHAR_DEL);
    endfunction

endpackage

// File: rtl/line_fifo_mem.sv
// Byte storage for the line buffer ring: synchronous write port,
// asynchronous (combinational) read port.
module line_fifo_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_r [DEPTH];

    // Write port: storage is intentionally not reset, the pointers define validity.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_line_buffer_chk.sv
// Runtime invariants of the line buffer: strobe spacing, occupancy bounds
// and pop legality. Carries no functional logic.
module uart_line_buffer_chk #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic              clock,
    input logic              reset,
    input logic              tx_strobe,
    input logic              pop,
    input logic [ADDR_W:0]   level,
    input logic [ADDR_W:0]   lines_pending
);

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_ZERO = {(ADDR_W+1){1'b0}};

    a_strobe_single: assert property (@(posedge clock) disable iff (reset)
        tx_strobe |=> !tx_strobe);

    a_level_bound: assert property (@(posedge clock) disable iff (reset)
        level <= LVL_FULL);

    a_lines_bound: assert property (@(posedge clock) disable iff (reset)
        lines_pending <= level);

    a_pop_nonempty: assert property (@(posedge clock) disable iff (reset)
        pop |-> (level != LVL_ZERO));

endmodule

// File: rtl/uart_line_buffer.sv
// Line-oriented echo buffer: collects received bytes and replays whole lines
// to the transmitter. Define UART_LINE_BUFFER_BKSP_EN to enable BS/DEL editing.
module uart_line_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int HOLDOFF = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rx_strobe,
    input  logic [7:0]      rx_byte,
    input  logic            tx_busy,
    output logic            tx_strobe,
    output logic [7:0]      tx_byte,
    output logic            overflow,
    output logic [ADDR_W:0] level
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [ADDR_W:0]   LVL_ZERO   = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LVL_ONE    = (ADDR_W+1)'(32'd1);
    localparam logic [ADDR_W:0]   LVL_FULL   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ALMOST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(32'd1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(32'd1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLDOFF - 1);

    line_state_e       state_r;
    line_state_e       state_next_s;

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_next_s;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_next_s;
    logic [ADDR_W:0]   level_r;
    logic [ADDR_W:0]   level_next_s;
    logic [ADDR_W:0]   lines_pending_r;
    logic [ADDR_W:0]   lines_next_s;
    logic [ADDR_W:0]   open_count_r;
    logic [ADDR_W:0]   open_next_s;
    logic              force_flush_r;
    logic              force_next_s;
    logic              overflow_r;

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_next_s;
    logic              tx_strobe_r;
    logic              strobe_next_s;
    logic [7:0]        tx_byte_r;
    logic [7:0]        tx_byte_next_s;

    logic [7:0]        rd_data_s;
    logic              pop_s;
    logic              edit_s;
    logic              edit_ok_s;
    logic              data_s;
    logic              wr_en_s;
    logic              drop_s;
    logic              wr_term_s;
    logic              pop_term_s;
    logic              pop_open_s;
    logic              drain_s;
    logic              hold_done_s;

    line_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (rx_byte),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Write acceptance, edit handling and terminator bookkeeping.
    always_comb begin
`ifdef UART_LINE_BUFFER_BKSP_EN
        edit_s = rx_strobe && is_edit(rx_byte);
`else
        edit_s = 1'b0;
`endif
        data_s     = rx_strobe && !edit_s;
        wr_en_s    = data_s && ((level_r != LVL_FULL) || pop_s);
        drop_s     = data_s && !wr_en_s;
        edit_ok_s  = edit_s && (open_count_r != LVL_ZERO) && !force_flush_r;
        wr_term_s  = wr_en_s && is_terminator(rx_byte);
        pop_term_s = pop_s && is_terminator(rd_data_s);
        // With no complete line stored, every popped byte belongs to the open line.
        pop_open_s = pop_s && (lines_pending_r == LVL_ZERO) && (open_count_r != LVL_ZERO);
        drain_s    = ((lines_pending_r != LVL_ZERO) || force_flush_r) && (level_r != LVL_ZERO);
    end

    // Next values of pointers and occupancy counters.
    always_comb begin
        if (wr_en_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else if (edit_ok_s) begin
            wr_ptr_next_s = wr_ptr_r - PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        rd_ptr_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

        level_next_s = level_r
                     + (wr_en_s   ? LVL_ONE : LVL_ZERO)
                     - (pop_s     ? LVL_ONE : LVL_ZERO)
                     - (edit_ok_s ? LVL_ONE : LVL_ZERO);

        lines_next_s = lines_pending_r
                     + (wr_term_s  ? LVL_ONE : LVL_ZERO)
                     - (pop_term_s ? LVL_ONE : LVL_ZERO);

        if (wr_term_s) begin
            open_next_s = LVL_ZERO;
        end else if (wr_en_s) begin
            open_next_s = open_count_r + LVL_ONE - (pop_open_s ? LVL_ONE : LVL_ZERO);
        end else if (edit_ok_s) begin
            open_next_s = open_count_r - LVL_ONE;
        end else begin
            open_next_s = open_count_r - (pop_open_s ? LVL_ONE : LVL_ZERO);
        end
    end

    // Forced drain starts when an unterminated line fills the buffer.
    always_comb begin
        if (wr_en_s && !pop_s && (level_r == LVL_ALMOST) &&
            (lines_pending_r == LVL_ZERO) && !is_terminator(rx_byte)) begin
            force_next_s = 1'b1;
        end else if (level_r == LVL_ZERO) begin
            force_next_s = 1'b0;
        end else begin
            force_next_s = force_flush_r;
        end
    end

    // FIFO pointers, counters and sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r        <= {ADDR_W{1'b0}};
            rd_ptr_r        <= {ADDR_W{1'b0}};
            level_r         <= LVL_ZERO;
            lines_pending_r <= LVL_ZERO;
            open_count_r    <= LVL_ZERO;
            force_flush_r   <= 1'b0;
            overflow_r      <= 1'b0;
        end else begin
            wr_ptr_r        <= wr_ptr_next_s;
            rd_ptr_r        <= rd_ptr_next_s;
            level_r         <= level_next_s;
            lines_pending_r <= lines_next_s;
            open_count_r    <= open_next_s;
            force_flush_r   <= force_next_s;
            overflow_r      <= overflow_r | drop_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        hold_done_s = (hold_cnt_r == HOLD_LAST);
        case (state_r)
            IDLE:    state_next_s = drain_s ? ISSUE : IDLE;
            ISSUE:   state_next_s = HOLD;
            HOLD:    state_next_s = hold_done_s ? WAIT : HOLD;
            WAIT: begin
                if (tx_busy) begin
                    state_next_s = WAIT;
                end else if (drain_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: pop in ISSUE, holdoff counting in HOLD.
    always_comb begin
        pop_s           = 1'b0;
        hold_cnt_next_s = HOLD_ZERO;
        case (state_r)
            ISSUE:   pop_s = 1'b1;
            HOLD:    hold_cnt_next_s = hold_cnt_r + HOLD_ONE;
            IDLE:    pop_s = 1'b0;
            WAIT:    pop_s = 1'b0;
            default: pop_s = 1'b0;
        endcase
        strobe_next_s  = pop_s;
        tx_byte_next_s = pop_s ? rd_data_s : tx_byte_r;
    end

    // Registered transmit interface and holdoff counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_strobe_r <= 1'b0;
            tx_byte_r   <= 8'h00;
            hold_cnt_r  <= HOLD_ZERO;
        end else begin
            tx_strobe_r <= strobe_next_s;
            tx_byte_r   <= tx_byte_next_s;
            hold_cnt_r  <= hold_cnt_next_s;
        end
    end

    assign tx_strobe = tx_strobe_r;
    assign tx_byte   = tx_byte_r;
    assign overflow  = overflow_r;
    assign level     = level_r;

    uart_line_buffer_chk #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clock         (clock),
        .reset         (reset),
        .tx_strobe     (tx_strobe_r),
        .pop           (pop_s),
        .level         (level_r),
        .lines_pending (lines_pending_r)
    );

endmodule
